q_measure: RTL and testbench
============================

// Module: q_measure
// PURPOSE
// Measurement front-end directly upstream of the bisection controller. Waits for a settling window
// after every i_ref change, then averages 2^AVG_LOG2 valid sensor samples of the quality factor.
// Presents the mean as q_measured with a one-cycle ready strobe, so the controller performs exactly
// one bisection step per fresh measurement.
// PARAMETERS
// BUS_WIDTH      10   width of i_ref, sample_in and q_measured
// AVG_LOG2       2    log2 of samples averaged per measurement (N = 2^AVG_LOG2, N >= 1)
// SETTLE_CYCLES  16   clocks discarded after enable rise / i_ref change / result (0 = no wait)
// PORTS
// clk             in   1          single clock; all logic on posedge
// rst             in   1          synchronous, active-high reset
// enable          in   1          measurement enable; low forces IDLE
// i_ref           in   BUS_WIDTH  current reference from bisection; any change restarts settling
// sample_valid    in   1          sample_in qualifier, one sample per high cycle
// sample_in       in   BUS_WIDTH  raw unsigned Q sample from sensor interface
// q_measured      out  BUS_WIDTH  mean of last completed measurement, held between results
// ready           out  1          one-cycle strobe: q_measured just updated
// busy            out  1          high in SETTLE or ACCUM
// BEHAVIOUR
// - Reset (rst high at posedge): state=IDLE, q_measured=0, ready=0, busy=0, acc=0, cnt=0,
//   settle counter=0, i_ref_q<=i_ref. rst has priority over every other input.
// - i_ref_q: register of i_ref every cycle; ref_chg = (i_ref != i_ref_q).
// - States: IDLE, SETTLE, ACCUM. busy = (state != IDLE), registered with state.
// - IDLE: enable=1 -> SETTLE, settle counter loaded with SETTLE_CYCLES; acc/cnt cleared.
// - SETTLE: decrement per clock; samples ignored. Counter==0 -> ACCUM (SETTLE_CYCLES=0 -> SETTLE lasts
//   exactly 1 cycle). Settled samples accepted from the first ACCUM cycle.
// - ACCUM: sample_valid=1 -> acc += sample_in, cnt += 1. On the edge accepting the N-th sample:
//   q_measured <= (acc + sample_in) >> AVG_LOG2 (floor, unsigned); ready <= 1; acc,cnt cleared;
//   state -> SETTLE with counter reloaded (every result followed by a new settle window).
// - ready high exactly one cycle, coincident with the new q_measured value; never high otherwise.
// - Latency, constant i_ref, sample_valid always 1: enable rise -> ready = SETTLE_CYCLES+N+2 clocks.
// - Widths: acc is BUS_WIDTH+AVG_LOG2 bits, cnt is AVG_LOG2+1 bits; no overflow at all-ones input.
// - Priority each cycle (high to low): rst, enable=0, ref_chg, normal FSM step.
// - enable=0 in any state: -> IDLE next edge, acc/cnt cleared, no ready, q_measured held.
// - ref_chg=1 in SETTLE or ACCUM: -> SETTLE, counter reloaded, acc/cnt cleared, partial result dropped,
//   no ready, even if that cycle would have accepted the N-th sample. Ignored in IDLE.
// - ref_chg and enable rise together: enter SETTLE normally (single reload).
// - rst mid-measurement: partial data discarded, outputs to reset values next cycle.
// TESTING (BUS_WIDTH=10, AVG_LOG2=2, SETTLE_CYCLES=4)
// 1. rst high 2 clk, other inputs random -> q_measured=0, ready=0, busy=0; enable=0 keeps IDLE.
// 2. enable=1, i_ref=512 const, valid every cycle, samples 100,101,102,103 after settle -> ready one
//    cycle at clk 10 after enable rise, q_measured=101; samples during SETTLE not summed.
// 3. i_ref 512->256 after 2 accepted samples -> no ready; 4-cycle settle restarts; next result is
//    mean of the 4 post-change samples only (200 x4 -> 200).
// 4. all samples 1023 -> q_measured=1023 (acc 4092 fits 12 bits); samples 0 -> 0.
// 5. sample_valid 1,0,0,1,1,0,1 in ACCUM -> ready only after 4th valid; gaps not counted.
// 6. enable low mid-ACCUM -> IDLE next edge, busy=0, no ready, q_measured keeps prior 101;
//    rst mid-ACCUM -> q_measured=0, IDLE.

Source files
------------

// File: rtl/q_measure.sv
// Settle-then-average front-end: waits out a settling window, then averages 2^AVG_LOG2 valid samples.
// Latency: SETTLE_CYCLES+N+2 clocks from enable rise to ready, with constant i_ref and continuous samples.
// Backpressure: none; samples are accepted whenever sample_valid is high in ACCUM, and ready is a 1-cycle strobe.
module q_measure #(
    parameter int BUS_WIDTH     = 10,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 sample_valid,
    input  logic [BUS_WIDTH-1:0] sample_in,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int AW = BUS_WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] q_q, q_d;
    logic                 ready_q, ready_d;
    logic [BUS_WIDTH-1:0] iref_q;
    logic                 ref_chg;
    logic [AW-1:0]        sum;

    assign ref_chg = (i_ref != iref_q);
    assign sum     = acc_q + AW'(sample_in);

    always_ff @(posedge clk) begin
        iref_q <= i_ref;
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            ready_q  <= ready_d;
        end
    end

    // Priority: enable low, then entry from IDLE, then reference change, then normal stepping.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        ready_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == IDLE || ref_chg) begin
            state_d  = SETTLE;
            settle_d = SW'(SETTLE_CYCLES);
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == SETTLE) begin
            if (settle_q == '0) state_d = ACCUM;
            else                settle_d = settle_q - SW'(1);
        end else if (sample_valid) begin
            if (cnt_q == CW'(N - 1)) begin
                q_d      = sum[AW-1:AVG_LOG2];
                ready_d  = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = SETTLE;
                settle_d = SW'(SETTLE_CYCLES);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        ready      = ready_q;
        q_measured = q_q;
    end

endmodule

// File: tb/tb_q_measure.sv
// Bench for q_measure: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a sample-list model of the settle/average rules.
module tb_q_measure;

    localparam int BW = 10;
    localparam int AL = 2;
    localparam int SC = 4;
    localparam int N  = 1 << AL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [BW-1:0] i_ref = '0;
    logic          sample_valid = 1'b0;
    logic [BW-1:0] sample_in = '0;
    logic [BW-1:0] q_measured;
    logic          ready;
    logic          busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    q_measure #(.BUS_WIDTH(BW), .AVG_LOG2(AL), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_ref(i_ref),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .q_measured(q_measured), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Model: a measurement is a list of accepted samples, opened after a wait of SC+1 clocks.
    int m_q = 0, m_ready = 0, m_active = 0, m_wait = 0, m_prev = 0;
    int m_list[$];
    bit cmp_en = 1'b0;

    always @(posedge clk) begin
        int sum;
        bit chg;
        if (rst) begin
            m_q = 0; m_ready = 0; m_active = 0; m_wait = 0;
            m_list.delete();
            m_prev = int'(i_ref);
            cmp_en = 1'b1;
        end else begin
            m_ready = 0;
            chg = (int'(i_ref) != m_prev);
            m_prev = int'(i_ref);
            if (!enable) begin
                m_active = 0;
                m_list.delete();
            end else if (!m_active || chg) begin
                m_active = 1;
                m_wait = SC + 1;
                m_list.delete();
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (sample_valid) begin
                m_list.push_back(int'(sample_in));
                if (m_list.size() == N) begin
                    sum = 0;
                    foreach (m_list[i]) sum += m_list[i];
                    m_q = sum / N;
                    m_ready = 1;
                    m_list.delete();
                    m_wait = SC + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model q_measured", int'(q_measured), m_q);
            chk("model ready", int'(ready), m_ready);
            chk("model busy", int'(busy), m_active);
        end
    end

    logic          s_rst[32], s_en[32], s_vld[32];
    logic [BW-1:0] s_ref[32], s_smp[32];

    task automatic fill(input int ref0, input int smp0);
        for (int k = 0; k < 32; k++) begin
            s_rst[k] = 1'b0; s_en[k] = (k > 0); s_vld[k] = 1'b1;
            s_ref[k] = BW'(ref0); s_smp[k] = BW'(smp0);
        end
    endtask

    // k=0 is a disabled cycle so every sequence starts from IDLE; k=1 is the enable-rise edge.
    task automatic run_seq(input int n, input int rdy_k, input int exp_q, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = s_rst[k]; enable = s_en[k]; i_ref = s_ref[k];
            sample_valid = s_vld[k]; sample_in = s_smp[k];
            @(posedge clk); #1;
            if (k == rdy_k) begin
                chk({nm, " ready"}, int'(ready), 1);
                chk({nm, " q"}, int'(q_measured), exp_q);
            end else if (rdy_k < 0 || k < rdy_k) begin
                chk({nm, " no ready"}, int'(ready), 0);
            end
        end
    endtask

    initial begin
        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            rst = 1'b1; enable = 1'($urandom); i_ref = BW'($urandom);
            sample_valid = 1'($urandom); sample_in = BW'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        chk("reset q", int'(q_measured), 0);
        chk("reset ready", int'(ready), 0);
        chk("reset busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 chk("idle busy", int'(busy), 0);

        // Basic measurement: settle samples of 900 must not be summed
        fill(512, 900);
        for (int k = 7; k <= 10; k++) s_smp[k] = BW'(100 + k - 7);
        run_seq(12, 10, 101, "basic");

        // Reference change after two accepted samples
        fill(512, 300);
        for (int k = 9; k < 32; k++) s_ref[k] = BW'(256);
        for (int k = 15; k < 32; k++) s_smp[k] = BW'(200);
        run_seq(20, 18, 200, "refchg");

        fill(0, 1023);
        run_seq(11, 10, 1023, "all ones");
        fill(0, 0);
        run_seq(11, 10, 0, "zeros");

        // Valid gaps in ACCUM: 1,0,0,1,1,0,1
        fill(7, 555);
        s_vld[8] = 1'b0; s_vld[9] = 1'b0; s_vld[12] = 1'b0;
        s_smp[7] = 10; s_smp[10] = 20; s_smp[11] = 30; s_smp[13] = 41;
        run_seq(15, 13, 25, "gaps");

        fill(512, 900);
        for (int k = 7; k <= 10; k++) s_smp[k] = BW'(100 + k - 7);
        run_seq(11, 10, 101, "basic2");

        // Enable dropped mid-ACCUM
        fill(512, 100);
        for (int k = 9; k < 32; k++) s_en[k] = 1'b0;
        run_seq(12, -1, 0, "enable drop");
        chk("enable drop busy", int'(busy), 0);
        chk("enable drop q held", int'(q_measured), 101);

        // Reset mid-ACCUM
        fill(512, 100);
        s_rst[8] = 1'b1;
        for (int k = 9; k < 32; k++) s_en[k] = 1'b0;
        run_seq(10, -1, 0, "mid reset");
        chk("mid reset q", int'(q_measured), 0);
        chk("mid reset busy", int'(busy), 0);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 47) != 0);
            if ($urandom_range(0, 39) == 0) i_ref = BW'($urandom);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_in = ($urandom_range(0, 3) == 0) ? BW'(1023) : BW'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
